// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - reset sequencer and clock-enable scheduler for the write/read domain pair
// Releases the write domain, then the read domain, and strobes per-domain enables at latched divide ratios.
module clk_rst_seq #(
  parameter int DIV_W = 4,
  parameter int HOLD  = 8,
  parameter int GAP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] wdiv,
  input  logic [DIV_W-1:0] rdiv,
  output logic             w_rst,
  output logic             r_rst,
  output logic             w_en,
  output logic             r_en,
  output logic             ready,
  output logic             cfg_err
);

  localparam int SEQ_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_REL_W,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state, state_nx;
  logic [SEQ_W-1:0] seq_cnt, seq_cnt_nx;
  logic [DIV_W-1:0] wdiv_q, rdiv_q, wdiv_nx, rdiv_nx;
  logic [DIV_W-1:0] wcnt, rcnt, wcnt_nx, rcnt_nx;
  logic [DIV_W-1:0] wlast, rlast;
  logic             w_rst_nx, r_rst_nx, w_en_nx, r_en_nx, ready_nx, cfg_err_nx;
  logic             cfg_bad;

  assign cfg_bad = (wdiv < DIV_W'(2)) || (rdiv < DIV_W'(2));
  assign wlast   = wdiv_q - DIV_W'(1);
  assign rlast   = rdiv_q - DIV_W'(1);

  always_comb begin
    state_nx   = state;
    seq_cnt_nx = seq_cnt + SEQ_W'(1);
    wdiv_nx    = wdiv_q;
    rdiv_nx    = rdiv_q;
    w_rst_nx   = w_rst;
    r_rst_nx   = r_rst;
    cfg_err_nx = 1'b0;

    case (state)
      S_IDLE: begin
        seq_cnt_nx = '0;
        w_rst_nx   = 1'b0;
        r_rst_nx   = 1'b0;
        if (start) begin
          if (cfg_bad) begin
            cfg_err_nx = 1'b1;
          end else begin
            wdiv_nx  = wdiv;
            rdiv_nx  = rdiv;
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (seq_cnt == HOLD_LAST) begin
          state_nx   = S_REL_W;
          w_rst_nx   = 1'b1;
          seq_cnt_nx = '0;
        end
      end
      S_REL_W: begin
        if (seq_cnt == GAP_LAST) begin
          state_nx   = S_RUN;
          r_rst_nx   = 1'b1;
          seq_cnt_nx = '0;
        end
      end
      S_RUN: begin
        seq_cnt_nx = '0;
        if (stop) begin
          state_nx = S_DRAIN;
          r_rst_nx = 1'b0;
        end
      end
      S_DRAIN: begin
        if (seq_cnt == GAP_LAST) begin
          state_nx   = S_IDLE;
          w_rst_nx   = 1'b0;
          seq_cnt_nx = '0;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        seq_cnt_nx = '0;
        w_rst_nx   = 1'b0;
        r_rst_nx   = 1'b0;
      end
    endcase

    // A counter starts at 0 in the first released cycle and stays cleared while its reset is low.
    if (!w_rst_nx || !w_rst)   wcnt_nx = '0;
    else if (wcnt == wlast)    wcnt_nx = '0;
    else                       wcnt_nx = wcnt + DIV_W'(1);

    if (!r_rst_nx || !r_rst)   rcnt_nx = '0;
    else if (rcnt == rlast)    rcnt_nx = '0;
    else                       rcnt_nx = rcnt + DIV_W'(1);

    w_en_nx  = w_rst_nx && (wcnt_nx == wlast);
    r_en_nx  = r_rst_nx && (rcnt_nx == rlast);
    ready_nx = w_rst_nx && r_rst_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      seq_cnt <= '0;
      wdiv_q  <= '0;
      rdiv_q  <= '0;
      wcnt    <= '0;
      rcnt    <= '0;
      w_rst   <= 1'b0;
      r_rst   <= 1'b0;
      w_en    <= 1'b0;
      r_en    <= 1'b0;
      ready   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      seq_cnt <= seq_cnt_nx;
      wdiv_q  <= wdiv_nx;
      rdiv_q  <= rdiv_nx;
      wcnt    <= wcnt_nx;
      rcnt    <= rcnt_nx;
      w_rst   <= w_rst_nx;
      r_rst   <= r_rst_nx;
      w_en    <= w_en_nx;
      r_en    <= r_en_nx;
      ready   <= ready_nx;
      cfg_err <= cfg_err_nx;
    end
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Reset sequencer and clock-enable scheduler for the write/read domain pair of the FIFO datapath. Runs on the single fast system clock.
- Holds both domain resets asserted, then releases the write domain first and the read domain a fixed gap later.
- While running, generates single-cycle write and read clock-enable strobes at programmable integer divide ratios (e.g. ÷2 write, ÷3 read).
- Drives the active-low domain resets of the clock divider and gates downstream enables; reports ready and configuration errors.

## Interface
Parameters:
- DIV_W, 4: width of divide-ratio inputs and internal phase counters
- HOLD, 8: cycles both domain resets stay asserted after start is accepted (≥1)
- GAP, 4: cycles between write-domain release and read-domain release, and between read-domain and write-domain assertion on stop (≥1)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset; synchronous, active-high
- start  in  1  request power-up sequence; sampled only in IDLE
- stop  in  1  request shutdown sequence; sampled only in RUN
- wdiv  in  DIV_W  write-domain divide ratio; latched on start accept
- rdiv  in  DIV_W  read-domain divide ratio; latched on start accept
- w_rst  out  1  write-domain reset, active-low (0 = domain held in reset)
- r_rst  out  1  read-domain reset, active-low
- w_en  out  1  write-domain clock-enable strobe, one cycle every wdiv cycles
- r_en  out  1  read-domain clock-enable strobe, one cycle every rdiv cycles
- ready  out  1  high while both domains are released (RUN)
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- All outputs registered. On rst (synchronous): state IDLE, counters 0, w_rst=0, r_rst=0, w_en=0, r_en=0, ready=0, cfg_err=0. rst overrides all other inputs, in every state.
- States: IDLE, HOLD, REL_W, RUN, DRAIN.
- IDLE:
  - Both resets low, enables low.
  - On start: if wdiv<2 or rdiv<2, pulse cfg_err and stay in IDLE. Otherwise latch wdiv/rdiv, go to HOLD.
  - stop is ignored.
- HOLD: resets low for HOLD cycles, then go to REL_W with w_rst=1.
- REL_W:
  - w_rst high; write phase counter runs.
  - After GAP cycles, go to RUN with r_rst=1 and ready=1.
- RUN:
  - Both resets high; both phase counters run.
  - On stop, go to DRAIN with r_rst=0, ready=0, r_en=0.
- DRAIN:
  - r_rst low; write counter keeps running and w_en continues.
  - After GAP cycles, w_rst=0, w_en=0, go to IDLE.
- Phase counters:
  - DIV_W bits wide; cleared while the corresponding reset is low.
  - Count 0..div-1 and wrap to 0.
  - Enable is high in the cycle the counter equals div-1.
- start is ignored outside IDLE. stop is ignored outside RUN. start and stop together in RUN: stop wins.
- wdiv/rdiv changes after latch have no effect until the next accepted start.
- Max ratio is 2^DIV_W−1. Ratios 0 and 1 are rejected via cfg_err.

## Timing
- Edge 0 is the edge that accepts start.
  - w_rst rises after edge HOLD.
  - r_rst and ready rise after edge HOLD+GAP.
- w_en is high in cycles HOLD+k·wdiv−1, for k≥1, counted from edge 0.
- r_en is high in cycles HOLD+GAP+k·rdiv−1, for k≥1.
- cfg_err is high for exactly the one cycle after the rejecting edge.
- Edge S is the edge that accepts stop.
  - r_rst, ready and r_en are low from the cycle after edge S.
  - w_rst and w_en are low from the cycle after edge S+GAP.
  - start is accepted again from edge S+GAP+1.
- rst at any edge: all outputs at reset values in the next cycle. No partial sequence resumes.

## Test plan
- Reset: assert rst for 2 cycles mid-RUN -> next cycle w_rst=r_rst=w_en=r_en=ready=cfg_err=0, state IDLE.
- Power-up, HOLD=8, GAP=4, wdiv=2, rdiv=3:
  - w_rst rises after edge 8; r_rst and ready rise after edge 12.
  - w_en high at cycles 9, 11, 13, …
  - r_en high at cycles 14, 17, 20, …
- Config reject: start with rdiv=1 -> cfg_err high for one cycle; resets stay 0; a later start with rdiv=3 is accepted normally.
- Shutdown: stop in RUN at edge S -> r_rst, ready, r_en low after S; w_en keeps its ÷2 pattern for 4 cycles; w_rst low after S+4; state IDLE.
- Collisions:
  - start+stop together in RUN -> shutdown sequence.
  - start during HOLD -> ignored, timing unchanged.
  - wdiv change during RUN -> w_en period unchanged.
- Max ratio: wdiv=15, rdiv=15 (DIV_W=4) -> w_en period 15, r_en period 15, no counter overflow over 100 cycles.
